sng_array: RTL and testbench

SNG_ARRAY -- requirements
Module: sng_array

---
 rtl/sng_pkg.sv | 16 +
 rtl/sng_if.sv | 29 ++
 rtl/sng_wbg_sel.sv | 26 ++
 rtl/sng_array.sv | 150 +++++++++++++++
 tb/tb_sng_array.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sng_pkg.sv
// Shared definitions for the stochastic number generator array:
// FSM state encoding and default geometry.
package sng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned BW_DEF     = 4;
  localparam int unsigned CH_DEF     = 4;
  localparam int unsigned REP_W_DEF  = 4;
  localparam int unsigned STRIDE_DEF = 5;

endpackage

// File: rtl/sng_if.sv
// Bundle of the control, operand and stream signals of sng_array, so a
// driver (master) and the generator (slave) can share one connection.
interface sng_if #(
  parameter int unsigned BW    = sng_pkg::BW_DEF,
  parameter int unsigned CH    = sng_pkg::CH_DEF,
  parameter int unsigned REP_W = sng_pkg::REP_W_DEF
);

  logic              start;
  logic              stop;
  logic [CH*BW-1:0]  x_bn;
  logic [REP_W-1:0]  reps;
  logic              decor;
  logic [CH-1:0]     sn_bits;
  logic              sn_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, stop, x_bn, reps, decor,
    input  sn_bits, sn_valid, busy, done
  );

  modport slave (
    input  start, stop, x_bn, reps, decor,
    output sn_bits, sn_valid, busy, done
  );

endinterface

// File: rtl/sng_wbg_sel.sv
// Weighted-binary bit selector: picks value bit BW-1-t, where t is the
// number of trailing ones of the count; an all-ones count yields 0.
module sng_wbg_sel #(
  parameter int unsigned BW = sng_pkg::BW_DEF
) (
  input  logic [BW-1:0] cnt_i,
  input  logic [BW-1:0] val_i,
  output logic          bit_o
);

  logic run_s;
  logic bit_s;

  // Walk up from the LSB; the first zero of the count selects the value bit.
  always_comb begin
    run_s = 1'b1;
    bit_s = 1'b0;
    for (int i = 0; i < BW; i++) begin
      bit_s = bit_s | (run_s & ~cnt_i[i] & val_i[BW-1-i]);
      run_s = run_s & cnt_i[i];
    end
  end

  assign bit_o = bit_s;

endmodule

// File: rtl/sng_array.sv
// Multi-channel stochastic number generator: shared period/repeat counters
// drive CH weighted-binary selectors, optionally decorrelated per channel.
module sng_array
  import sng_pkg::*;
#(
  parameter int unsigned BW     = BW_DEF,
  parameter int unsigned CH     = CH_DEF,
  parameter int unsigned REP_W  = REP_W_DEF,
  parameter int unsigned STRIDE = STRIDE_DEF
) (
  input  logic              i_clk_sng_arr,
  input  logic              i_rst_n_sng_arr,
  input  logic              i_start_sng_arr,
  input  logic              i_stop_sng_arr,
  input  logic [CH*BW-1:0]  i_x_bn,
  input  logic [REP_W-1:0]  i_reps,
  input  logic              i_decor,
  output logic [CH-1:0]     o_sn_bits,
  output logic              o_sn_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [BW-1:0] C_MAX = {BW{1'b1}};

  state_e             state_q;
  logic [BW-1:0]      c_q;
  logic [REP_W-1:0]   rep_q;
  logic [CH*BW-1:0]   x_q;
  logic [REP_W-1:0]   reps_q;
  logic               decor_q;
  logic [CH-1:0]      bits_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [BW-1:0]      sel_c_s;
  logic [CH*BW-1:0]   sel_x_s;
  logic               sel_dec_s;
  logic [REP_W-1:0]   last_rep_s;
  logic [CH-1:0]      ch_bit_s;

  // Selectors look at the count about to be emitted, so outputs stay registered.
  always_comb begin
    sel_c_s    = '0;
    sel_x_s    = x_q;
    sel_dec_s  = decor_q;
    last_rep_s = (reps_q == '0) ? '0 : reps_q - REP_W'(1'b1);
    if (state_q == ST_IDLE) begin
      sel_x_s   = i_x_bn;
      sel_dec_s = i_decor;
    end else begin
      sel_c_s = c_q + BW'(1'b1);
    end
  end

  for (genvar j = 0; j < CH; j++) begin : g_ch
    localparam int unsigned   OFF_FULL = j * STRIDE;
    localparam logic [BW-1:0] OFF      = OFF_FULL[BW-1:0];
    logic [BW-1:0] cj_s;

    assign cj_s = sel_dec_s ? (sel_c_s ^ OFF) : sel_c_s;

    sng_wbg_sel #(.BW(BW)) u_sel (
      .cnt_i (cj_s),
      .val_i (sel_x_s[j*BW +: BW]),
      .bit_o (ch_bit_s[j])
    );
  end

  // Control FSM with its counters, operand latches and registered outputs.
  always_ff @(posedge i_clk_sng_arr or negedge i_rst_n_sng_arr) begin
    if (!i_rst_n_sng_arr) begin
      state_q <= ST_IDLE;
      c_q     <= '0;
      rep_q   <= '0;
      x_q     <= '0;
      reps_q  <= '0;
      decor_q <= 1'b0;
      bits_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_start_sng_arr) begin
            x_q     <= i_x_bn;
            reps_q  <= i_reps;
            decor_q <= i_decor;
            c_q     <= '0;
            rep_q   <= '0;
            bits_q  <= ch_bit_s;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_GEN;
          end else begin
            bits_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_GEN: begin
          // Abort wins even on the final bit of the stream.
          if (i_stop_sng_arr) begin
            c_q     <= '0;
            rep_q   <= '0;
            bits_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if ((c_q == C_MAX) && (rep_q == last_rep_s)) begin
            bits_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            c_q     <= c_q + BW'(1'b1);
            rep_q   <= (c_q == C_MAX) ? rep_q + REP_W'(1'b1) : rep_q;
            bits_q  <= ch_bit_s;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          c_q     <= '0;
          rep_q   <= '0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          c_q     <= '0;
          rep_q   <= '0;
          bits_q  <= '0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_sn_bits  = bits_q;
  assign o_sn_valid = valid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_sng_array.sv
// Self-checking bench for sng_array: table-driven streams plus random ones,
// compared cycle by cycle against a trailing-ones reference model.
module tb_sng_array;

  localparam int BW     = 4;
  localparam int CH     = 4;
  localparam int REP_W  = 4;
  localparam int STRIDE = 5;
  localparam int PER    = 1 << BW;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [PER-1:0] seq [CH];

  sng_if #(.BW(BW), .CH(CH), .REP_W(REP_W)) bus ();

  sng_array #(.BW(BW), .CH(CH), .REP_W(REP_W), .STRIDE(STRIDE)) dut (
    .i_clk_sng_arr   (clk),
    .i_rst_n_sng_arr (rst_n),
    .i_start_sng_arr (bus.start),
    .i_stop_sng_arr  (bus.stop),
    .i_x_bn          (bus.x_bn),
    .i_reps          (bus.reps),
    .i_decor         (bus.decor),
    .o_sn_bits       (bus.sn_bits),
    .o_sn_valid      (bus.sn_valid),
    .o_busy          (bus.busy),
    .o_done          (bus.done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CH*BW-1:0] x;
    logic [REP_W-1:0] reps;
    logic             decor;
    int               stop_at;
    int               exp_nvalid;
    int               exp_ndone;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: bit t below the MSB of x_j, t = trailing ones of the (offset) count.
  function automatic logic [CH-1:0] model_bits(input logic [CH*BW-1:0] x, input logic decor, input int c);
    logic [CH-1:0] r;
    r = '0;
    for (int j = 0; j < CH; j++) begin
      int cj;
      int t;
      int v;
      int xj;
      cj = decor ? (c ^ ((j * STRIDE) % PER)) : c;
      t  = 0;
      v  = cj;
      while (t < BW && (v % 2) == 1) begin
        t++;
        v = v / 2;
      end
      xj = int'((x >> (j * BW)) & (CH*BW)'(PER - 1));
      r[j] = (t == BW) ? 1'b0 : 1'(((xj >> (BW - 1 - t)) & 1));
    end
    return r;
  endfunction

  function automatic int x_of(input logic [CH*BW-1:0] x, input int j);
    return int'((x >> (j * BW)) & (CH*BW)'(PER - 1));
  endfunction

  task automatic run_stream(input logic [CH*BW-1:0] x, input logic [REP_W-1:0] reps,
                            input logic decor, input int stop_at, input logic with_stop,
                            output int nvalid, output int ndone);
    int reps_eff;
    int nexp;
    int kmax;
    int ones [CH];
    logic [CH-1:0] exp_bits;
    logic exp_valid;
    logic exp_done;
    logic exp_busy;
    reps_eff = (reps == '0) ? 1 : int'(reps);
    nexp     = (stop_at >= 0) ? stop_at + 1 : PER * reps_eff;
    kmax     = (stop_at >= 0) ? stop_at + 1 : nexp + 2;
    nvalid   = 0;
    ndone    = 0;
    for (int j = 0; j < CH; j++) ones[j] = 0;
    bus.x_bn  = x;
    bus.reps  = reps;
    bus.decor = decor;
    bus.start = 1'b1;
    bus.stop  = with_stop;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.x_bn  = (CH*BW)'($urandom);
    bus.reps  = REP_W'($urandom);
    bus.decor = 1'($urandom);
    for (int k = 0; k <= kmax; k++) begin
      exp_valid = (k < nexp);
      exp_done  = (stop_at < 0) && (k == nexp);
      exp_busy  = (stop_at < 0) ? (k <= nexp) : (k < nexp);
      exp_bits  = exp_valid ? model_bits(x, decor, k % PER) : '0;
      check($sformatf("valid@%0d", k), 32'(bus.sn_valid), 32'(exp_valid));
      check($sformatf("done@%0d", k),  32'(bus.done),     32'(exp_done));
      check($sformatf("busy@%0d", k),  32'(bus.busy),     32'(exp_busy));
      check($sformatf("bits@%0d", k),  32'(bus.sn_bits),  32'(exp_bits));
      if (bus.sn_valid) begin
        nvalid++;
        for (int j = 0; j < CH; j++) begin
          ones[j] += int'(bus.sn_bits[j]);
          if (k < PER) seq[j][k] = bus.sn_bits[j];
        end
      end
      if (bus.done) ndone++;
      // Start is legal noise while busy; stop only at its slot or in DONE.
      bus.start = ((stop_at < 0) ? (k <= nexp) : (k <= stop_at)) ? 1'($urandom) : 1'b0;
      bus.stop  = (k == stop_at) ? 1'b1 : ((stop_at < 0 && k == nexp) ? 1'($urandom) : 1'b0);
      if (k < kmax) @(negedge clk);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    if (stop_at < 0) begin
      for (int j = 0; j < CH; j++)
        check($sformatf("ones_ch%0d", j), 32'(ones[j]), 32'(x_of(x, j) * reps_eff));
    end
  endtask

  initial begin
    int nv;
    int nd;
    logic [CH*BW-1:0] rx;
    logic [REP_W-1:0] rr;
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h9F50, 4'd1, 1'b0, -1, 16, 1};
    vecs[1] = '{16'h1C38, 4'd1, 1'b0, -1, 16, 1};
    vecs[2] = '{16'h6666, 4'd1, 1'b1, -1, 16, 1};
    vecs[3] = '{16'hA2D7, 4'd3, 1'b0, -1, 48, 1};
    vecs[4] = '{16'h4B1E, 4'd0, 1'b1, -1, 16, 1};
    vecs[5] = '{16'h5A3C, 4'd2, 1'b0,  5,  6, 0};
    vecs[6] = '{16'h0F81, 4'd1, 1'b0, -1, 16, 1};
    vecs[7] = '{16'hC3E5, 4'd1, 1'b1, 15, 16, 0};
    vecs[8] = '{16'hFFFF, 4'd2, 1'b1, -1, 32, 1};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.x_bn  = '0;
    bus.reps  = '0;
    bus.decor = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.sn_valid), 32'd0);
    check("rst_bits",  32'(bus.sn_bits),  32'd0);
    check("rst_busy",  32'(bus.busy),     32'd0);
    check("rst_done",  32'(bus.done),     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vectors 5 and 6 run back to back: the stop is followed by an immediate restart.
    for (int i = 0; i < 9; i++) begin
      run_stream(vecs[i].x, vecs[i].reps, vecs[i].decor, vecs[i].stop_at, 1'b0, nv, nd);
      check($sformatf("v%0d_nvalid", i), 32'(nv), 32'(vecs[i].exp_nvalid));
      check($sformatf("v%0d_ndone", i),  32'(nd), 32'(vecs[i].exp_ndone));
      if (i == 2) check("decor_ch0_ne_ch1", 32'(seq[0] != seq[1]), 32'd1);
      if (i == 1) check("v1_ch0_pattern", 32'(seq[0]), 32'h5555);
    end

    for (int r = 0; r < 6; r++) begin
      rx = (CH*BW)'($urandom);
      rr = REP_W'($urandom_range(0, 3));
      run_stream(rx, rr, 1'($urandom), -1, 1'b0, nv, nd);
      check($sformatf("rnd%0d_nvalid", r), 32'(nv), 32'(PER * ((rr == '0) ? 1 : int'(rr))));
      check($sformatf("rnd%0d_ndone", r),  32'(nd), 32'd1);
    end

    // Mid-stream asynchronous reset, with start held high while busy.
    @(negedge clk);
    bus.x_bn  = 16'h3579;
    bus.reps  = 4'd2;
    bus.decor = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    repeat (7) @(negedge clk);
    check("pre_rst_valid", 32'(bus.sn_valid), 32'd1);
    check("pre_rst_bits",  32'(bus.sn_bits),  32'(model_bits(16'h3579, 1'b0, 7)));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.sn_valid), 32'd0);
    check("async_rst_bits",  32'(bus.sn_bits),  32'd0);
    check("async_rst_busy",  32'(bus.busy),     32'd0);
    check("async_rst_done",  32'(bus.done),     32'd0);
    bus.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_stream(16'h8E42, 4'd1, 1'b1, -1, 1'b1, nv, nd);
    check("startstop_nvalid", 32'(nv), 32'd16);
    check("startstop_ndone",  32'(nd), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
